// File: rtl/sram_port_ctrl_pkg.sv
// Shared sizing defaults and grant encoding for the single-port SRAM controller.
package sram_port_ctrl_pkg;

    localparam int unsigned SRAM_DEPTH     = 4096;
    localparam int unsigned ADDR_W_DEF     = $clog2(SRAM_DEPTH);
    localparam int unsigned DATA_W_DEF     = 7;
    localparam int unsigned RESP_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_RD   = 2'd1,
        GRANT_WR   = 2'd2
    } grant_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order read response buffer; the head entry is presented continuously.
module sram_resp_fifo #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sram_port_ctrl.sv
// Arbitrates write and read requests onto one SRAM RW port and returns read
// data through a small credit-checked response buffer.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    grant_e           grant;
    logic             prio;
    logic             rd_pend;
    logic             resp_pop;
    logic             rd_req;
    logic             contested;
    logic [CNT_W-1:0] resp_count;
    logic [CNT_W:0]   credit_used;

    // A pop this cycle frees its slot immediately, so a full buffer can re-admit a read.
    assign resp_pop    = resp_valid & resp_ready;
    assign credit_used = (CNT_W + 1)'(resp_count) + (CNT_W + 1)'(rd_pend)
                       - (CNT_W + 1)'(resp_pop);
    assign rd_req      = r_valid & (credit_used < (CNT_W + 1)'(RESP_DEPTH));
    assign contested   = reset_n & rd_req & w_valid;

    // Priority bit only arbitrates contested cycles: 0 favours the read.
    always_comb begin
        grant = GRANT_NONE;
        if (reset_n) begin
            if (rd_req && w_valid) begin
                grant = prio ? GRANT_WR : GRANT_RD;
            end else if (rd_req) begin
                grant = GRANT_RD;
            end else if (w_valid) begin
                grant = GRANT_WR;
            end
        end
    end

    assign r_ready    = (grant == GRANT_RD);
    assign w_ready    = (grant == GRANT_WR);
    assign sram_en    = (grant != GRANT_NONE);
    assign sram_wmode = (grant == GRANT_WR);
    assign sram_addr  = (grant == GRANT_WR) ? w_addr : r_addr;
    assign sram_wdata = w_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio    <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            prio    <= prio ^ contested;
            rd_pend <= (grant == GRANT_RD);
        end
    end

    // SRAM data returns one cycle after the read enable; capture it then.
    sram_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH),
        .CNT_W  (CNT_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rd_pend),
        .push_data (sram_rdata),
        .pop       (resp_pop),
        .head_data (resp_data),
        .count     (resp_count)
    );

    assign resp_valid = (resp_count != '0);

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed, table-driven bench for sram_port_ctrl with a behavioural SRAM.
module tb_sram_port_ctrl;

    logic        clock;
    logic        reset_n;
    logic        w_valid;
    logic        w_ready;
    logic [11:0] w_addr;
    logic [6:0]  w_data;
    logic        r_valid;
    logic        r_ready;
    logic [11:0] r_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [6:0]  resp_data;
    logic [11:0] sram_addr;
    logic        sram_en;
    logic        sram_wmode;
    logic [6:0]  sram_wdata;
    logic [6:0]  sram_rdata;

    logic [6:0]  mem [4096];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        wv;
        logic [11:0] wa;
        logic [6:0]  wd;
        logic        rv;
        logic [11:0] ra;
        logic        rr;
        logic        ew;
        logic        er;
        logic        ev;
        logic [6:0]  ed;
    } vec_t;

    sram_port_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_addr     (r_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    // Single-port SRAM: write-through disabled, read data one cycle after enable.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= mem[sram_addr];
        end
    end

    function automatic vec_t mk(input logic wv, input logic [11:0] wa, input logic [6:0] wd,
                                input logic rv, input logic [11:0] ra, input logic rr,
                                input logic ew, input logic er, input logic ev,
                                input logic [6:0] ed);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
        v.ew = ew; v.er = er; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got=%0h want=%0h", tag, what, act, exp);
        end
    endtask

    // Called at a negative edge: drive, settle, compare, advance one cycle.
    task automatic apply(input vec_t v, input string tag);
        w_valid    = v.wv;
        w_addr     = v.wa;
        w_data     = v.wd;
        r_valid    = v.rv;
        r_addr     = v.ra;
        resp_ready = v.rr;
        #1;
        chk(tag, "w_ready", 32'(w_ready), 32'(v.ew));
        chk(tag, "r_ready", 32'(r_ready), 32'(v.er));
        chk(tag, "sram_en", 32'(sram_en), 32'(v.ew | v.er));
        chk(tag, "sram_wmode", 32'(sram_wmode), 32'(v.ew));
        if (v.ew | v.er) chk(tag, "sram_addr", 32'(sram_addr), 32'(v.ew ? v.wa : v.ra));
        if (v.ew) chk(tag, "sram_wdata", 32'(sram_wdata), 32'(v.wd));
        chk(tag, "resp_valid", 32'(resp_valid), 32'(v.ev));
        if (v.ev) chk(tag, "resp_data", 32'(resp_data), 32'(v.ed));
        @(negedge clock);
    endtask

    task automatic run(input vec_t q[$], input string name);
        for (int i = 0; i < q.size(); i++) begin
            apply(q[i], $sformatf("%s[%0d]", name, i));
        end
    endtask

    initial begin
        vec_t tab[$];
        vec_t sa[$];
        vec_t sb[$];
        vec_t sc[$];

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        clock = 1'b0;
        sram_rdata = '0;
        reset_n = 1'b0;

        // Main table: write/read round trips, top address, contested arbitration.
        tab.push_back(mk(1, 12'h005, 7'h2A, 0, 12'h000, 1, 1, 0, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 1, 12'h005, 1, 0, 1, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h2A));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));
        tab.push_back(mk(1, 12'hFFF, 7'h7F, 0, 12'h000, 1, 1, 0, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 1, 12'hFFF, 1, 0, 1, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h7F));
        tab.push_back(mk(1, 12'h010, 7'h11, 1, 12'h005, 1, 0, 1, 0, 7'h00));
        tab.push_back(mk(1, 12'h010, 7'h11, 1, 12'h005, 1, 1, 0, 0, 7'h00));
        tab.push_back(mk(1, 12'h020, 7'h22, 1, 12'h010, 1, 0, 1, 1, 7'h2A));
        tab.push_back(mk(1, 12'h020, 7'h22, 1, 12'h020, 1, 1, 0, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h11));
        tab.push_back(mk(0, 12'h000, 7'h00, 1, 12'h020, 1, 0, 1, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h22));
        tab.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));

        // Backpressure: third read stalls, write still proceeds, pop re-admits a read.
        sa.push_back(mk(0, 12'h000, 7'h00, 1, 12'h005, 0, 0, 1, 0, 7'h00));
        sa.push_back(mk(0, 12'h000, 7'h00, 1, 12'hFFF, 0, 0, 1, 0, 7'h00));
        sa.push_back(mk(0, 12'h000, 7'h00, 1, 12'h010, 0, 0, 0, 1, 7'h2A));
        sa.push_back(mk(0, 12'h000, 7'h00, 1, 12'h010, 0, 0, 0, 1, 7'h2A));
        sa.push_back(mk(1, 12'h030, 7'h33, 1, 12'h010, 0, 1, 0, 1, 7'h2A));
        sa.push_back(mk(0, 12'h000, 7'h00, 1, 12'h010, 1, 0, 1, 1, 7'h2A));
        sa.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 0, 0, 0, 1, 7'h7F));
        sa.push_back(mk(0, 12'h000, 7'h00, 1, 12'h020, 1, 0, 1, 1, 7'h7F));
        sa.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h11));
        sa.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h22));
        sa.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));

        // Reset window: requests present but nothing may issue.
        sb.push_back(mk(1, 12'h020, 7'h55, 1, 12'h010, 1, 0, 0, 0, 7'h00));
        sb.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));

        // After reset: priority back to read-first, stale read discarded, 0x020 intact.
        sc.push_back(mk(1, 12'h030, 7'h5C, 1, 12'h020, 1, 0, 1, 0, 7'h00));
        sc.push_back(mk(1, 12'h030, 7'h5C, 1, 12'h020, 1, 1, 0, 0, 7'h00));
        sc.push_back(mk(0, 12'h000, 7'h00, 1, 12'h030, 1, 0, 1, 1, 7'h22));
        sc.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));
        sc.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 1, 7'h5C));
        sc.push_back(mk(0, 12'h000, 7'h00, 0, 12'h000, 1, 0, 0, 0, 7'h00));

        @(negedge clock);
        run(sb, "rst0");
        reset_n = 1'b1;
        @(negedge clock);

        run(tab, "tab");
        run(sa, "bp");

        // Contested read fires (priority flips to write), then reset one cycle later.
        apply(mk(1, 12'h040, 7'h44, 1, 12'h005, 1, 0, 1, 0, 7'h00), "pre_rst");
        reset_n = 1'b0;
        run(sb, "rst1");
        reset_n = 1'b1;
        run(sc, "post");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning SRAM address width (depth 4096).
REQ-002 The block SHALL have parameter DATA_W, default 7, meaning SRAM word width.
REQ-003 The block SHALL have parameter RESP_DEPTH, default 2, meaning response buffer entries (fixed at 2 for this revision).
REQ-004 The block SHALL have port clock, input, 1, meaning the single clock.
REQ-005 The block SHALL have port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have ports w_valid/w_ready (input/output, 1), w_addr (input, ADDR_W) and w_data (input, DATA_W), meaning the write request channel.
REQ-007 The block SHALL have ports r_valid/r_ready (input/output, 1) and r_addr (input, ADDR_W), meaning the read request channel.
REQ-008 The block SHALL have ports resp_valid/resp_ready (output/input, 1) and resp_data (output, DATA_W), meaning the read response channel.
REQ-009 The block SHALL have outputs sram_addr (ADDR_W), sram_en (1), sram_wmode (1) and sram_wdata (DATA_W), meaning drives to the single-port SRAM RW port.
REQ-010 The block SHALL have input sram_rdata (DATA_W), meaning SRAM read data, valid 1 cycle after a read enable.

Function
REQ-011 A transfer SHALL occur on a channel when valid and ready are both high at a rising clock edge.
REQ-012 At most one SRAM operation SHALL issue per cycle.
REQ-013 The SRAM port SHALL be driven combinationally: sram_en = write fire OR read fire, sram_wmode = write fire, sram_addr/sram_wdata from the granted channel.
REQ-014 When both channels request in the same cycle, a priority bit SHALL select the winner (0 = read first) and toggle after every contested grant.
REQ-015 An uncontested request SHALL be granted regardless of the priority bit, and the bit SHALL NOT change.
REQ-016 A read SHALL be granted only if buffered entries plus in-flight reads is less than 2.
REQ-017 A granted read in cycle N SHALL capture sram_rdata into the response buffer at the edge ending cycle N+1, so resp_valid rises in cycle N+2 at the earliest.
REQ-018 The response buffer SHALL be a 2-entry FIFO that preserves read order, presents the head on resp_data, and keeps resp_valid high while non-empty.
REQ-019 A simultaneous push and pop on the response buffer SHALL keep the occupancy unchanged.
REQ-020 A pop from a full buffer SHALL re-enable read grant in the same cycle through the credit check.
REQ-021 resp_data SHALL hold stable while resp_valid is high and resp_ready is low.
REQ-022 A write in cycle N followed by a read of the same address in cycle N+1 or later SHALL return the new data, with no extra stall.
REQ-023 w_ready SHALL be independent of response buffer state.

Reset
REQ-024 When reset_n is low, the block SHALL immediately hold sram_en=0, w_ready=0, r_ready=0, resp_valid=0, buffer empty, in-flight=0 and priority bit=0.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight read and buffered responses, and SRAM contents SHALL not be written.
REQ-026 Request acceptance SHALL resume on the first edge after reset_n deasserts.

Structure
REQ-027 A shared package SHALL hold ADDR_W/DATA_W defaults, SRAM depth, and the grant encoding (GRANT_NONE/GRANT_RD/GRANT_WR).
REQ-028 The response FIFO SHALL be the sub-module sram_resp_fifo, with push/pop, data and a count output.

Verification
REQ-029 Write addr 0x005 data 0x2A, then read 0x005 next cycle -> resp_data=0x2A with resp_valid in cycle 3 after read fire.
REQ-030 w_valid and r_valid held high for 4 cycles after reset -> grants R,W,R,W and the priority bit toggles each cycle.
REQ-031 resp_ready=0 with 3 back-to-back reads -> third r_ready low until one pop, and no response is lost or reordered.
REQ-032 Full buffer with simultaneous pop and arriving read data -> count stays 2 and order is preserved.
REQ-033 reset_n pulsed low one cycle after a read fire -> no resp_valid after reset, and a later read returns the written value.
REQ-034 Read of addr 0xFFF after writing 0x7F there -> returns 0x7F (top-address boundary).
